// File: rtl/line_fill_arbiter_if.sv
// Cache-side and memory-side signal bundle of the line fill arbiter.
// The slave modport is the arbiter's view; master is the view of the caches plus memory.
interface line_fill_arbiter_if #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_W     = 2
);
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic                 i_gnt;
    logic                 i_rvalid;
    logic                 i_done;
    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_rvalid;
    logic                 d_done;
    logic [IDX_W-1:0]     word_idx;
    logic [WORD_SIZE-1:0] rdata;
    logic [WORD_SIZE-1:0] mem_addr;
    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_done, d_rvalid, d_done, word_idx, rdata,
               mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_done, d_rvalid, d_done, word_idx, rdata,
               mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/line_fill_arbiter.sv
// Round-robin arbiter sharing one single-port memory between I-cache refills and
// D-cache refills/writebacks; whole-line bursts after a fixed access delay.
module line_fill_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int LINE_SIZE   = 4,
    parameter int MEM_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    line_fill_arbiter_if.slave    bus
);
    localparam int IDX_W  = $clog2(LINE_SIZE);
    localparam int TAG_W  = WORD_SIZE - IDX_W;
    localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t               state_q, state_d;
    owner_t               owner_q, owner_d;
    owner_t               last_grant_q, last_grant_d;
    logic                 we_q, we_d;
    logic [TAG_W-1:0]     line_q, line_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [IDX_W-1:0]     beat_q, beat_d;

    logic                 i_gnt_q, i_gnt_d;
    logic                 i_rvalid_q, i_rvalid_d;
    logic                 d_rvalid_q, d_rvalid_d;
    logic                 i_done_q, i_done_d;
    logic                 d_done_q, d_done_d;
    logic [IDX_W-1:0]     word_idx_q, word_idx_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic                 burst_s;

    // Word-offset bits of the request addresses are deliberately ignored.
    logic unused_addr_s;
    assign unused_addr_s = ^{bus.i_addr[IDX_W-1:0], bus.d_addr[IDX_W-1:0]};

    // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        line_d       = line_q;
        wait_d       = wait_q;
        beat_d       = beat_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    if (bus.i_req && bus.d_req) begin
                        owner_d = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
                    end else if (bus.d_req) begin
                        owner_d = OWN_D;
                    end else begin
                        owner_d = OWN_I;
                    end
                    last_grant_d = owner_d;
                    if (owner_d == OWN_D) begin
                        line_d = bus.d_addr[WORD_SIZE-1:IDX_W];
                        we_d   = bus.d_we;
                    end else begin
                        line_d = bus.i_addr[WORD_SIZE-1:IDX_W];
                        we_d   = 1'b0;
                    end
                    wait_d  = WAIT_W'(MEM_LATENCY - 1);
                    beat_d  = '0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_BURST;
                    beat_d  = '0;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_BURST: begin
                // The beat only ever fills the word-offset bits, so the line wraps within itself.
                if (beat_q == IDX_W'(LINE_SIZE - 1)) begin
                    state_d = ST_DONE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        burst_s     = (state_d == ST_BURST);
        mem_read_d  = burst_s && !we_d;
        mem_write_d = burst_s && we_d;
        mem_addr_d  = burst_s ? {line_d, beat_d} : '0;
        i_gnt_d     = (state_d != ST_IDLE) && (owner_d == OWN_I);
        i_done_d    = (state_d == ST_DONE) && (owner_d == OWN_I);
        d_done_d    = (state_d == ST_DONE) && (owner_d == OWN_D);
        i_rvalid_d  = mem_read_q && (owner_q == OWN_I);
        d_rvalid_d  = mem_read_q && (owner_q == OWN_D);

        // Reads report the index of the beat whose data returns now; writes report the beat being written.
        if (mem_read_q) begin
            word_idx_d = mem_addr_q[IDX_W-1:0];
        end else if (mem_write_d) begin
            word_idx_d = beat_d;
        end else begin
            word_idx_d = '0;
        end
    end

    // State and output registers; reset aborts any transfer without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            we_q         <= 1'b0;
            line_q       <= '0;
            wait_q       <= '0;
            beat_q       <= '0;
            i_gnt_q      <= 1'b0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            word_idx_q   <= '0;
            mem_addr_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            line_q       <= line_d;
            wait_q       <= wait_d;
            beat_q       <= beat_d;
            i_gnt_q      <= i_gnt_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            word_idx_q   <= word_idx_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign bus.i_gnt     = i_gnt_q;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.word_idx  = word_idx_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.rdata     = bus.mem_rdata;
    // Writeback data comes straight from the requester, indexed by word_idx.
    assign bus.mem_wdata = mem_write_q ? bus.d_wdata : '0;
endmodule

// File: tb/tb_line_fill_arbiter.sv
// Directed bench for line_fill_arbiter: reads, writebacks, round-robin ties,
// ignored request changes, mid-burst reset and back-to-back transactions.
module tb_line_fill_arbiter;
    localparam int W  = 16;
    localparam int IW = 2;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    line_fill_arbiter_if #(.WORD_SIZE(W), .IDX_W(IW)) bif ();

    line_fill_arbiter #(.WORD_SIZE(W), .LINE_SIZE(4), .MEM_LATENCY(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] a);
        case (a)
            16'h0024: return 16'hA0A0;
            16'h0025: return 16'hB1B1;
            16'h0026: return 16'hC2C2;
            16'h0027: return 16'hD3D3;
            16'h0030: return 16'h3000;
            16'h0031: return 16'h3001;
            16'h0032: return 16'h3002;
            16'h0033: return 16'h3003;
            default:  return ~a;
        endcase
    endfunction

    // Memory model: read data appears one cycle after mem_read.
    always @(posedge clk) begin
        if (bif.mem_read) bif.mem_rdata <= rom(bif.mem_addr);
    end

    assign bif.d_wdata = 16'h1111 * ({14'd0, bif.word_idx} + 16'd1);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %04h expected %04h", tag, got, exp);
        end
    endtask

    task automatic i_read(input logic [15:0] base, input logic keep);
        bif.i_addr = base | 16'h0001;
        bif.i_req  = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk1("i_gnt", bif.i_gnt, 1'b1);
            chk1("i_mem_read", bif.mem_read, (k >= 5 && k <= 8));
            chk1("i_mem_write", bif.mem_write, 1'b0);
            chk16("i_mem_addr", bif.mem_addr, (k >= 5 && k <= 8) ? base + 16'(k - 5) : 16'h0000);
            chk1("i_rvalid", bif.i_rvalid, (k >= 6));
            chk1("i_d_rvalid", bif.d_rvalid, 1'b0);
            chk1("i_done", bif.i_done, (k == 9));
            if (k >= 6) begin
                chk16("i_word_idx", {14'd0, bif.word_idx}, 16'(k - 6));
                chk16("i_rdata", bif.rdata, rom(base + 16'(k - 6)));
            end
        end
        if (!keep) bif.i_req = 1'b0;
    endtask

    task automatic d_write(input logic drop);
        bif.d_addr = 16'h0040;
        bif.d_we   = 1'b1;
        bif.d_req  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk1("w_mem_write", bif.mem_write, (k >= 5 && k <= 8));
            chk1("w_mem_read", bif.mem_read, 1'b0);
            chk16("w_mem_addr", bif.mem_addr, (k >= 5 && k <= 8) ? 16'h0040 + 16'(k - 5) : 16'h0000);
            chk16("w_mem_wdata", bif.mem_wdata, (k >= 5 && k <= 8) ? 16'h1111 * 16'(k - 4) : 16'h0000);
            chk16("w_word_idx", {14'd0, bif.word_idx}, (k >= 5 && k <= 8) ? 16'(k - 5) : 16'h0000);
            chk1("w_d_rvalid", bif.d_rvalid, 1'b0);
            chk1("w_d_done", bif.d_done, (k == 9));
            chk1("w_i_gnt", bif.i_gnt, 1'b0);
            if (drop && k == 2) begin
                bif.d_req  = 1'b0;
                bif.d_addr = 16'h0080;
                bif.d_we   = 1'b0;
            end
            if (!drop && k == 9) bif.d_req = 1'b0;
        end
    endtask

    initial begin
        clk         = 1'b0;
        reset_n     = 1'b0;
        vectors     = 0;
        miscompares = 0;
        bif.i_req   = 1'b0;
        bif.i_addr  = 16'h0000;
        bif.d_req   = 1'b0;
        bif.d_we    = 1'b0;
        bif.d_addr  = 16'h0000;
        step();
        step();

        chk1("rst_i_gnt", bif.i_gnt, 1'b0);
        chk1("rst_mem_read", bif.mem_read, 1'b0);
        chk1("rst_mem_write", bif.mem_write, 1'b0);
        chk1("rst_i_done", bif.i_done, 1'b0);
        chk1("rst_d_done", bif.d_done, 1'b0);
        chk1("rst_i_rvalid", bif.i_rvalid, 1'b0);
        chk1("rst_d_rvalid", bif.d_rvalid, 1'b0);
        chk16("rst_mem_addr", bif.mem_addr, 16'h0000);
        chk16("rst_word_idx", {14'd0, bif.word_idx}, 16'h0000);
        chk16("rst_mem_wdata", bif.mem_wdata, 16'h0000);
        reset_n = 1'b1;
        step();

        // Basic I-side line read of 0x24..0x27.
        i_read(16'h0024, 1'b0);
        step();
        chk1("idle_i_gnt", bif.i_gnt, 1'b0);
        chk1("idle_i_done", bif.i_done, 1'b0);

        // Fresh reset, then simultaneous requests: D first, I next, D again.
        reset_n = 1'b0;
        step();
        chk1("rst2_i_gnt", bif.i_gnt, 1'b0);
        reset_n = 1'b1;
        step();
        bif.i_addr = 16'h0010;
        bif.d_addr = 16'h0031;
        bif.d_we   = 1'b0;
        bif.i_req  = 1'b1;
        bif.d_req  = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk1("tie1_i_gnt", bif.i_gnt, 1'b0);
            chk1("tie1_d_done", bif.d_done, (k == 9));
            chk1("tie1_i_done", bif.i_done, 1'b0);
            chk1("tie1_i_rvalid", bif.i_rvalid, 1'b0);
            if (k == 5) chk16("tie1_mem_addr", bif.mem_addr, 16'h0030);
            if (k == 6) begin
                chk1("tie1_d_rvalid", bif.d_rvalid, 1'b1);
                chk16("tie1_rdata", bif.rdata, 16'h3000);
            end
        end
        bif.d_req = 1'b0;
        step();
        chk1("tie_idle_i_gnt", bif.i_gnt, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk1("tie2_i_gnt", bif.i_gnt, 1'b1);
            chk1("tie2_i_done", bif.i_done, (k == 9));
            chk1("tie2_d_rvalid", bif.d_rvalid, 1'b0);
            if (k == 5) chk16("tie2_mem_addr", bif.mem_addr, 16'h0010);
            if (k == 6) chk16("tie2_rdata", bif.rdata, 16'hFFEF);
        end
        bif.i_req = 1'b0;
        step();
        bif.i_req = 1'b1;
        bif.d_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk1("tie3_i_gnt", bif.i_gnt, 1'b0);
            chk1("tie3_d_done", bif.d_done, (k == 9));
        end
        bif.i_req = 1'b0;
        bif.d_req = 1'b0;
        step();

        // Writeback held to completion, then one whose request changes during WAIT.
        d_write(1'b0);
        d_write(1'b1);

        // Reset in the middle of a burst.
        bif.i_addr = 16'h0024;
        bif.i_req  = 1'b1;
        repeat (6) step();
        chk1("mid_pre_mem_read", bif.mem_read, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("mid_mem_read", bif.mem_read, 1'b0);
        chk1("mid_i_gnt", bif.i_gnt, 1'b0);
        chk1("mid_i_rvalid", bif.i_rvalid, 1'b0);
        chk16("mid_mem_addr", bif.mem_addr, 16'h0000);
        chk16("mid_word_idx", {14'd0, bif.word_idx}, 16'h0000);
        for (int k = 0; k < 2; k++) begin
            step();
            chk1("mid_i_done", bif.i_done, 1'b0);
        end
        reset_n = 1'b1;

        // Restart with full latency, holding i_req across done for a back-to-back read.
        i_read(16'h0024, 1'b1);
        step();
        chk1("b2b_idle_i_gnt", bif.i_gnt, 1'b0);
        chk1("b2b_idle_mem_read", bif.mem_read, 1'b0);
        i_read(16'h0024, 1'b0);
        step();
        chk1("end_i_gnt", bif.i_gnt, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/line_fill_arbiter.md
Name: line_fill_arbiter

Overview:
- Shares one single-port backing memory between the instruction-cache refill path (I side) and the data-cache refill/writeback path (D side).
- Accepts whole-line requests, arbitrates between the two sides round-robin, inserts a fixed access delay, then bursts LINE_SIZE consecutive words.
- Sits between the split I/D caches and the word-addressed main memory array; the caches hold their miss state until done.

Parameters:
WORD_SIZE, 16, data and address width
LINE_SIZE, 4, words per line (power of two); IDX_W = log2(LINE_SIZE)
MEM_LATENCY, 4, wait cycles between grant and first word (>=1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
i_req  in  1  I-side line read request, level, held until i_done
i_addr  in  WORD_SIZE  I-side address; low IDX_W bits ignored
i_gnt  out  1  I side owns the memory (WAIT through DONE)
i_rvalid  out  1  i_rdata valid this cycle
i_done  out  1  one-cycle pulse, I transfer complete
d_req  in  1  D-side request, level, held until d_done
d_we  in  1  1 = line writeback, 0 = line fill; sampled at grant
d_addr  in  WORD_SIZE  D-side address; low IDX_W bits ignored
d_wdata  in  WORD_SIZE  writeback word selected by word_idx, combinational from requester
d_rvalid  out  1  d_rdata valid this cycle
d_done  out  1  one-cycle pulse, D transfer complete
word_idx  out  IDX_W  word index of current read-data beat (reads) or current write beat (writes)
rdata  out  WORD_SIZE  read data, shared by both sides = mem_rdata
mem_addr  out  WORD_SIZE  memory address
mem_read  out  1  memory read strobe; data on mem_rdata next cycle
mem_write  out  1  memory write strobe; mem_wdata written at this edge
mem_wdata  out  WORD_SIZE  = d_wdata during write beats, else 0
mem_rdata  in  WORD_SIZE  memory read data, one cycle after mem_read

Behaviour:
- Reset (async, any state): state=IDLE, counters=0, all outputs 0, last_grant=I. The first simultaneous request after reset therefore goes to D. An in-flight transfer is aborted with no done pulse.
- States: IDLE, WAIT, BURST, DONE.
- IDLE: samples i_req and d_req.
  - One request high: grant that side.
  - Both high: grant the side not in last_grant.
  - On grant: latch the line address {addr[W-1:IDX_W], 0}, latch d_we (forced 0 for I), update last_grant, go to WAIT with wait_cnt=MEM_LATENCY-1.
- WAIT: lasts MEM_LATENCY cycles. Decrement each cycle; at 0 go to BURST with beat=0.
- BURST: lasts exactly LINE_SIZE cycles.
  - Each cycle: mem_addr = {line, beat}.
  - Read: mem_read=1.
  - Write: mem_write=1, mem_wdata=d_wdata, word_idx=beat.
  - beat increments each cycle; after beat=LINE_SIZE-1, go to DONE.
- Read data: x_rvalid is registered, high in the cycle after each mem_read, with word_idx = beat of that read. Valid beats occupy BURST cycles 2..LINE_SIZE plus the DONE cycle.
- DONE: one cycle. Owner's x_done=1; last read beat also valid here. Next state is IDLE.
- Requester protocol: drop req at the edge on which it samples done=1. A req still high in the following IDLE cycle is a new transaction.
- Latency: req sampled in IDLE at cycle T gives done at T+MEM_LATENCY+LINE_SIZE+1 (T+9 at defaults). Back-to-back transactions cost one extra IDLE cycle.
- Request changes after grant (req drop, addr/d_we change) are ignored; the transfer always completes. The other side's req waits, unaffected.
- i_gnt and d_gnt (internal for D, exposed only for I) are mutually exclusive and never both high. Strobes mem_read and mem_write are never both high and are 0 outside BURST.
- Address arithmetic: beat index fills the low IDX_W bits only; there is no carry into tag/index bits, so the line wraps within itself.

Test Plan:
- Reset, then i_req=1, i_addr=0x0025 (mem[0x24..0x27]=A,B,C,D) → mem_read at 0x24..0x27 in cycles T+5..T+8; i_rvalid T+6..T+9 with word_idx 0..3 and data A..D; i_done=1 at T+9 only.
- i_req and d_req both high in the same cycle after reset → D granted first; I granted in the IDLE after d_done; next tie → D again (I was last).
- d_req=1, d_we=1, d_addr=0x0040, bench returns d_wdata=0x1111*(word_idx+1) → mem_write at 0x40..0x43 with data 0x1111..0x4444; d_done after 9 cycles; no d_rvalid.
- d_req dropped and d_addr changed to 0x0080 during WAIT → burst still hits 0x40..0x43 and d_done still pulses.
- reset_n low mid-BURST → outputs 0 immediately, no done pulse; after release, same i_req restarts with full latency.
- i_req held high across done → second transaction starts in the following IDLE cycle, done 10 cycles after the first.
